// File: rtl/npu_pe_pkg.sv
// Shared definitions for the NPU processing elements: default widths and os_mode encoding.
package npu_pe_pkg;

  localparam int unsigned PE_DW = 8;
  localparam int unsigned PE_AW = 24;

  // os_mode encoding: weight-stationary pass-through vs output-stationary accumulate
  typedef enum logic {
    PE_MODE_WS = 1'b0,
    PE_MODE_OS = 1'b1
  } pe_mode_e;

endpackage

// File: rtl/pe_sys_mac_if.sv
// Data/control bundle of one systolic PE; master drives operands, slave is the PE.
interface pe_sys_mac_if #(
  parameter int unsigned DW = npu_pe_pkg::PE_DW,
  parameter int unsigned AW = npu_pe_pkg::PE_AW
);

  logic signed [DW-1:0] w_in;
  logic                 w_load;
  logic                 w_swap;
  logic signed [DW-1:0] a_in;
  logic                 a_vld;
  logic signed [AW-1:0] c_in;
  logic                 os_mode;
  logic                 flush;
  logic                 Err_mult;
  logic                 Err_mac;
  logic signed [DW-1:0] a_out;
  logic                 a_vld_out;
  logic signed [AW-1:0] c_out;
  logic                 c_vld;
  logic                 ovf;

  modport master (
    output w_in, w_load, w_swap, a_in, a_vld, c_in, os_mode, flush, Err_mult, Err_mac,
    input  a_out, a_vld_out, c_out, c_vld, ovf
  );

  modport slave (
    input  w_in, w_load, w_swap, a_in, a_vld, c_in, os_mode, flush, Err_mult, Err_mac,
    output a_out, a_vld_out, c_out, c_vld, ovf
  );

endinterface

// File: rtl/pe_mult_stage.sv
// Stage 1 of the PE: signed DWxDW multiply, sign extension to AW, optional
// product-LSB fault flip, registered on a_vld. Fault hook enabled by PE_FAULT_INJ_EN.
module pe_mult_stage #(
  parameter int unsigned DW = npu_pe_pkg::PE_DW,
  parameter int unsigned AW = npu_pe_pkg::PE_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] weight,
  input  logic signed [DW-1:0] act,
  input  logic                 vld,
  input  logic                 err_mult,
  output logic signed [AW-1:0] prod
);

  localparam int unsigned PW = 2 * DW;

  logic signed [PW-1:0] mult;
  logic signed [AW-1:0] prod_d;

  assign mult = PW'(weight) * PW'(act);

`ifdef PE_FAULT_INJ_EN
  assign prod_d = AW'(mult) ^ AW'(err_mult);
`else
  logic unused_err_mult;
  assign unused_err_mult = err_mult;
  assign prod_d          = AW'(mult);
`endif

  // Product register, only advances on a valid activation
  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
    end else if (vld) begin
      prod <= prod_d;
    end
  end

endmodule

// File: rtl/pe_sys_mac.sv
// Pipelined systolic PE: double-buffered weight, registered activation forwarding,
// 2-stage MAC with WS pass-through or OS accumulate, sticky overflow.
// Optional fault-injection hooks (Err_mult/Err_mac) built only with PE_FAULT_INJ_EN.
module pe_sys_mac
  import npu_pe_pkg::*;
#(
  parameter int unsigned DW = PE_DW,
  parameter int unsigned AW = PE_AW
) (
  input logic         clk,
  input logic         rst,
  pe_sys_mac_if.slave bus
);

  if (AW < 2 * DW) begin : g_aw_check
    $error("pe_sys_mac: AW must be at least 2*DW");
  end

  logic signed [DW-1:0] w_shadow;
  logic signed [DW-1:0] w_active;
  logic signed [AW-1:0] prod;

  logic                 s1_vld;
  logic                 s1_flush;
  pe_mode_e             s1_mode;
  logic signed [AW-1:0] s1_c;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] add_a;
  logic signed [AW-1:0] add_b;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] sum_f;
  logic                 ovf_now;
  logic                 os_flush;

  logic signed [DW-1:0] a_out_q;
  logic                 a_vld_out_q;
  logic signed [AW-1:0] c_out_q;
  logic                 c_vld_q;
  logic                 ovf_q;

  // Shadow/active weight pair; a same-cycle load+swap moves the old shadow into active
  always_ff @(posedge clk) begin
    if (rst) begin
      w_shadow <= '0;
      w_active <= '0;
    end else begin
      if (bus.w_load) w_shadow <= bus.w_in;
      if (bus.w_swap) w_active <= w_shadow;
    end
  end

  pe_mult_stage #(
    .DW(DW),
    .AW(AW)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .weight   (w_active),
    .act      (bus.a_in),
    .vld      (bus.a_vld),
    .err_mult (bus.Err_mult),
    .prod     (prod)
  );

  // Stage-1 side-band capture; flush and mode follow every cycle, c_in only with a_vld
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_flush <= 1'b0;
      s1_mode  <= PE_MODE_WS;
      s1_c     <= '0;
    end else begin
      s1_vld   <= bus.a_vld;
      s1_flush <= bus.flush;
      s1_mode  <= pe_mode_e'(bus.os_mode);
      if (bus.a_vld) s1_c <= bus.c_in;
    end
  end

  // Stage-2 adder operands, signed overflow and OS flush qualification
  always_comb begin
    add_a    = (s1_mode == PE_MODE_WS) ? s1_c : acc;
    add_b    = s1_vld ? prod : '0;
    sum      = add_a + add_b;
    ovf_now  = s1_vld && (add_a[AW-1] == add_b[AW-1]) && (sum[AW-1] != add_a[AW-1]);
    os_flush = (s1_mode == PE_MODE_OS) && s1_flush;
  end

`ifdef PE_FAULT_INJ_EN
  logic s1_err_mac;

  // Err_mac travels with its activation into stage 2
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_err_mac <= 1'b0;
    end else if (bus.a_vld) begin
      s1_err_mac <= bus.Err_mac;
    end
  end

  assign sum_f = sum ^ AW'(s1_err_mac & s1_vld);
`else
  logic unused_err_mac;
  assign unused_err_mac = bus.Err_mac;
  assign sum_f          = sum;
`endif

  // Stage 2: emit in WS, accumulate or drain in OS, sticky overflow cleared by OS flush
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      c_out_q <= '0;
      c_vld_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      c_vld_q <= 1'b0;
      if (s1_mode == PE_MODE_WS) begin
        if (s1_vld) begin
          c_out_q <= sum_f;
          c_vld_q <= 1'b1;
        end
      end else if (s1_flush) begin
        c_out_q <= sum_f;
        c_vld_q <= 1'b1;
        acc     <= '0;
      end else if (s1_vld) begin
        acc <= sum_f;
      end
      ovf_q <= (ovf_q && !os_flush) || ovf_now;
    end
  end

  // Activation forwarding to the east neighbour
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out_q     <= '0;
      a_vld_out_q <= 1'b0;
    end else begin
      a_out_q     <= bus.a_in;
      a_vld_out_q <= bus.a_vld;
    end
  end

  assign bus.a_out     = a_out_q;
  assign bus.a_vld_out = a_vld_out_q;
  assign bus.c_out     = c_out_q;
  assign bus.c_vld     = c_vld_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pe_sys_mac.sv
// Self-checking bench for pe_sys_mac: directed vector table, hand sequences for
// multi-cycle corners, and randomized traffic against a transaction-level model.
module tb_pe_sys_mac;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 24;
  localparam longint MAXV = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (AW - 1));
`ifdef PE_FAULT_INJ_EN
  localparam bit FI = 1'b1;
`else
  localparam bit FI = 1'b0;
`endif

  typedef struct {
    logic                 rst;
    logic signed [DW-1:0] w;
    logic                 wl;
    logic                 ws;
    logic signed [DW-1:0] a;
    logic                 av;
    logic signed [AW-1:0] c;
    logic                 mode;
    logic                 flush;
    logic                 em;
    logic                 ec;
  } in_t;

  typedef struct {
    logic                 vld;
    logic signed [AW-1:0] val;
    logic                 ovf;
  } res_t;

  typedef struct {
    logic signed [DW-1:0] w;
    logic signed [DW-1:0] a;
    logic signed [AW-1:0] c;
    logic                 em;
    logic                 ec;
    longint               exp;
  } vec_t;

  logic clk;
  logic rst;
  pe_sys_mac_if #(.DW(DW), .AW(AW)) bus ();

  pe_sys_mac #(.DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic g_mode = 1'b0;

  // model state: weights, accumulator, sticky flag, result due after the next edge
  logic signed [DW-1:0] m_sh, m_act;
  longint               m_acc;
  logic                 m_ovf;
  res_t                 pend;
  logic signed [AW-1:0] m_cout;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic in_t idle();
    in_t x;
    x.rst = 1'b0; x.w = '0; x.wl = 1'b0; x.ws = 1'b0; x.a = '0; x.av = 1'b0;
    x.c = '0; x.mode = g_mode; x.flush = 1'b0; x.em = 1'b0; x.ec = 1'b0;
    return x;
  endfunction

  function automatic bit out_of_range(input longint s);
    return (s > MAXV) || (s < MINV);
  endfunction

  task automatic drive(input in_t x);
    rst = x.rst;
    bus.w_in = x.w; bus.w_load = x.wl; bus.w_swap = x.ws;
    bus.a_in = x.a; bus.a_vld = x.av; bus.c_in = x.c;
    bus.os_mode = x.mode; bus.flush = x.flush;
    bus.Err_mult = x.em; bus.Err_mac = x.ec;
  endtask

  // Transaction-level reference: each accepted input is resolved immediately
  task automatic model(input in_t x);
    longint p, s;
    bit ov;
    logic signed [AW-1:0] r;
    if (x.rst) begin
      m_sh = '0; m_act = '0; m_acc = 0; m_ovf = 1'b0;
      pend.vld = 1'b0; pend.val = '0; pend.ovf = 1'b0;
      return;
    end
    p = longint'(m_act) * longint'(x.a);
    if (FI && x.em) p = p ^ 1;
    pend.vld = 1'b0;
    pend.val = '0;
    if (!x.mode) begin
      if (x.av) begin
        s = longint'(x.c) + p;
        ov = out_of_range(s);
        r = AW'(s);
        if (FI && x.ec) r[0] = ~r[0];
        pend.vld = 1'b1;
        pend.val = r;
        if (ov) m_ovf = 1'b1;
      end
    end else begin
      s = m_acc + (x.av ? p : 0);
      ov = x.av && out_of_range(s);
      r = AW'(s);
      if (FI && x.ec && x.av) r[0] = ~r[0];
      if (x.flush) begin
        pend.vld = 1'b1;
        pend.val = r;
        m_acc = 0;
        m_ovf = 1'b0;
      end else if (x.av) begin
        m_acc = longint'(r);
      end
      if (ov) m_ovf = 1'b1;
    end
    pend.ovf = m_ovf;
    if (x.ws) m_act = m_sh;
    if (x.wl) m_sh = x.w;
  endtask

  // One clock: apply inputs, advance the model, check all outputs after the edge
  task automatic cyc(input in_t x);
    res_t prev;
    prev = pend;
    drive(x);
    model(x);
    @(posedge clk);
    #1;
    if (x.rst) begin
      m_cout = '0;
      chk("rst_a_out", bus.a_out, 0);
      chk("rst_a_vld_out", bus.a_vld_out, 0);
      chk("rst_c_out", bus.c_out, 0);
      chk("rst_c_vld", bus.c_vld, 0);
      chk("rst_ovf", bus.ovf, 0);
    end else begin
      if (prev.vld) m_cout = prev.val;
      chk("a_out", bus.a_out, x.a);
      chk("a_vld_out", bus.a_vld_out, x.av);
      chk("c_vld", bus.c_vld, prev.vld);
      chk("c_out", bus.c_out, m_cout);
      chk("ovf", bus.ovf, prev.ovf);
    end
  endtask

  task automatic ld_sw(input logic signed [DW-1:0] w);
    in_t x;
    x = idle(); x.w = w; x.wl = 1'b1; cyc(x);
    x = idle(); x.ws = 1'b1; cyc(x);
  endtask

  task automatic op(input logic signed [DW-1:0] a, input logic signed [AW-1:0] c);
    in_t x;
    x = idle(); x.a = a; x.av = 1'b1; x.c = c; cyc(x);
  endtask

  initial begin
    vec_t tbl [8];
    in_t  x;

    tbl[0] = '{w:  87, a:  65, c:  43, em: 0, ec: 0, exp:  5698};
    tbl[1] = '{w: -87, a:  65, c:  43, em: 0, ec: 0, exp: -5612};
    tbl[2] = '{w: -87, a: -65, c:  43, em: 0, ec: 0, exp:  5698};
    tbl[3] = '{w:  87, a:  65, c: -43, em: 0, ec: 0, exp:  5612};
    tbl[4] = '{w: -87, a: -65, c: -43, em: 0, ec: 0, exp:  5612};
    tbl[5] = '{w:  87, a:  65, c:  43, em: 1, ec: 0, exp: FI ? 5697 : 5698};
    tbl[6] = '{w:  87, a:  65, c:  43, em: 0, ec: 1, exp: FI ? 5699 : 5698};
    tbl[7] = '{w:  87, a:  65, c:  43, em: 1, ec: 1, exp: FI ? 5696 : 5698};

    x = idle(); x.rst = 1'b1; cyc(x);
    cyc(idle());

    // weight-stationary vectors: result two cycles after a_vld
    foreach (tbl[i]) begin
      ld_sw(tbl[i].w);
      x = idle(); x.a = tbl[i].a; x.av = 1'b1; x.c = tbl[i].c;
      x.em = tbl[i].em; x.ec = tbl[i].ec;
      cyc(x);
      cyc(idle());
      chk($sformatf("vec%0d_vld", i), bus.c_vld, 1);
      chk($sformatf("vec%0d_c_out", i), bus.c_out, tbl[i].exp);
    end

    // output-stationary accumulate, swap, flush including the same-cycle product
    g_mode = 1'b1;
    ld_sw(87);
    op(65, 0);
    x = idle(); x.a = -65; x.av = 1'b1; x.w = 10; x.wl = 1'b1; cyc(x);
    x = idle(); x.ws = 1'b1; cyc(x);
    x = idle(); x.a = 10; x.av = 1'b1; x.flush = 1'b1; cyc(x);
    cyc(idle());
    chk("os_flush_vld", bus.c_vld, 1);
    chk("os_flush_c_out", bus.c_out, 100);
    cyc(idle());
    chk("os_single_pulse", bus.c_vld, 0);
    x = idle(); x.flush = 1'b1; cyc(x);
    cyc(idle());
    chk("os_empty_flush_vld", bus.c_vld, 1);
    chk("os_empty_flush_c_out", bus.c_out, 0);
    g_mode = 1'b0;

    // double buffer: load mid-stream, swap takes effect on the following activation
    ld_sw(3);
    for (int i = 0; i < 7; i++) begin
      x = idle();
      if (i < 6) begin x.a = 2; x.av = 1'b1; x.c = AW'(100 * i); end
      if (i == 1) begin x.w = 5; x.wl = 1'b1; end
      if (i == 3) x.ws = 1'b1;
      cyc(x);
      if (i >= 1) chk($sformatf("dbuf%0d", i - 1), bus.c_out, 100 * (i - 1) + ((i - 1) <= 3 ? 6 : 10));
    end
    x = idle(); x.w = 7; x.wl = 1'b1; x.ws = 1'b1; cyc(x);
    op(1, 0);
    x = idle(); x.ws = 1'b1; cyc(x);
    chk("simul_active", bus.c_out, 5);
    op(1, 0);
    cyc(idle());
    chk("simul_shadow", bus.c_out, 7);

    // signed overflow wraps and sticks until reset
    ld_sw(1);
    op(1, AW'(MAXV));
    cyc(idle());
    chk("ovf_wrap", bus.c_out, MINV);
    chk("ovf_set", bus.ovf, 1);
    op(1, 0);
    cyc(idle());
    chk("ovf_held", bus.ovf, 1);
    x = idle(); x.rst = 1'b1; cyc(x);
    chk("ovf_cleared", bus.ovf, 0);

    // reset with two results in flight
    ld_sw(87);
    op(65, 43);
    x = idle(); x.a = 65; x.av = 1'b1; x.c = 43; x.rst = 1'b1; cyc(x);
    chk("midrst_c_out", bus.c_out, 0);
    chk("midrst_a_out", bus.a_out, 0);
    cyc(idle());
    chk("midrst_no_vld", bus.c_vld, 0);
    op(5, 7);
    cyc(idle());
    chk("midrst_weight_gone", bus.c_out, 7);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) g_mode = ~g_mode;
      x = idle();
      x.rst   = ($urandom_range(0, 79) == 0);
      x.w     = DW'($urandom);
      x.wl    = ($urandom_range(0, 3) == 0);
      x.ws    = ($urandom_range(0, 3) == 0);
      x.a     = DW'($urandom);
      x.av    = ($urandom_range(0, 3) != 0);
      x.flush = ($urandom_range(0, 7) == 0);
      x.em    = ($urandom_range(0, 3) == 0);
      x.ec    = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       x.c = AW'(MAXV - longint'($urandom_range(0, 300)));
        1:       x.c = AW'(MINV + longint'($urandom_range(0, 300)));
        default: x.c = AW'($urandom);
      endcase
      cyc(x);
    end
    cyc(idle());
    cyc(idle());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
